// File: rtl/bus_pkg.sv
// bus_pkg: shared types and widths for the two-master bus arbiter.
//   state_e : arbiter FSM states (IDLE, ACCESS)
//   owner_e : bus owner encoding (M0 = CPU, M1 = DMA)
//   ADDR_W / DATA_W : bus address and data widths
package bus_pkg;

   localparam int ADDR_W = 16;
   localparam int DATA_W = 8;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACCESS = 1'b1
   } state_e;

   typedef enum logic {
      OWN_M0 = 1'b0,
      OWN_M1 = 1'b1
   } owner_e;

endpackage

// File: rtl/bus_arbiter_if.sv
// bus_arbiter_if: bundles both master request ports and the slave port.
// Signal names keep the arbiter's i_/o_ direction prefixes.
//   modport master : arbiter view (drives the slave bus and master acks)
//   modport slave  : environment view (masters and the slave device)
interface bus_arbiter_if;
   import bus_pkg::*;

   logic              i_m0_req,  i_m1_req;
   logic [ADDR_W-1:0] i_m0_addr, i_m1_addr;
   logic [DATA_W-1:0] i_m0_dat,  i_m1_dat;
   logic              i_m0_we,   i_m1_we;
   logic              o_m0_active, o_m1_active;
   logic              o_m0_ack,  o_m1_ack;
   logic [DATA_W-1:0] o_m_dat;
   logic [ADDR_W-1:0] o_s_addr;
   logic [DATA_W-1:0] o_s_dat;
   logic              o_s_we;
   logic              o_s_cs;
   logic [DATA_W-1:0] i_s_dat;
   logic              i_s_ack;
   logic              o_err;

   modport master (
      input  i_m0_req, i_m1_req, i_m0_addr, i_m1_addr, i_m0_dat, i_m1_dat,
             i_m0_we, i_m1_we, i_s_dat, i_s_ack,
      output o_m0_active, o_m1_active, o_m0_ack, o_m1_ack, o_m_dat,
             o_s_addr, o_s_dat, o_s_we, o_s_cs, o_err
   );

   modport slave (
      output i_m0_req, i_m1_req, i_m0_addr, i_m1_addr, i_m0_dat, i_m1_dat,
             i_m0_we, i_m1_we, i_s_dat, i_s_ack,
      input  o_m0_active, o_m1_active, o_m0_ack, o_m1_ack, o_m_dat,
             o_s_addr, o_s_dat, o_s_we, o_s_cs, o_err
   );

endinterface

// File: rtl/bus_timeout.sv
// bus_timeout: counts non-completing ACCESS cycles.
//   i_clk, i_reset_n : clock, async active-low reset
//   i_clr            : zero the count (has priority over i_en)
//   i_en             : advance the count by one
//   o_expired        : count has reached TIMEOUT-1
module bus_timeout #(
   parameter int TIMEOUT = 15
) (
   input  logic i_clk,
   input  logic i_reset_n,
   input  logic i_clr,
   input  logic i_en,
   output logic o_expired
);

   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n)                r_cnt <= '0;
      else if (i_clr)                r_cnt <= '0;
      else if (i_en && !o_expired)   r_cnt <= r_cnt + CNT_W'(1);
   end

   assign o_expired = (r_cnt == CNT_MAX);

endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master (CPU = m0, DMA = m1) single-slave bus arbiter.
//   i_clk     : clock, all state on rising edge
//   i_reset_n : async active-low reset
//   bus       : bus_arbiter_if.master -- master requests/acks, slave bus,
//               shared read data, timeout error pulse
// Ownership is held for up to MAX_HOLD completions while the other master
// waits; a slave that never acks is force-completed after TIMEOUT cycles.
// Optional feature: define BUS_ARB_ROUND_ROBIN_EN to break simultaneous
// IDLE requests toward the master that did not complete last; otherwise
// m0 has fixed priority.
module bus_arbiter
   import bus_pkg::*;
#(
   parameter int MAX_HOLD = 4,
   parameter int TIMEOUT  = 15
) (
   input  logic         i_clk,
   input  logic         i_reset_n,
   bus_arbiter_if.master bus
);

   localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
   localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD - 1);

   state_e            r_state, w_state_nxt;
   owner_e            r_owner, w_owner_nxt;
   logic [HOLD_W-1:0] r_hold,  w_hold_nxt;
   logic              r_err;
`ifdef BUS_ARB_ROUND_ROBIN_EN
   owner_e            r_last,  w_last_nxt;
`endif

   logic   w_access;
   logic   w_own_req, w_oth_req;
   logic   w_expired;
   logic   w_complete, w_abandon, w_timeout;
   logic   w_tmo_clr;
   owner_e w_grant, w_other;

   assign w_access  = (r_state == ST_ACCESS);
   assign w_own_req = (r_owner == OWN_M1) ? bus.i_m1_req : bus.i_m0_req;
   assign w_oth_req = (r_owner == OWN_M1) ? bus.i_m0_req : bus.i_m1_req;
   assign w_other   = (r_owner == OWN_M1) ? OWN_M0 : OWN_M1;

   // An owner that has withdrawn its request gets no ack, even if the
   // slave acks or the timer expires in that same cycle.
   assign w_complete = w_access && w_own_req && (bus.i_s_ack || w_expired);
   assign w_abandon  = w_access && !w_own_req;
   assign w_timeout  = w_complete && !bus.i_s_ack;

   // Count restarts for every new access: idle, completion or hand-over.
   assign w_tmo_clr = !w_access || w_complete || w_abandon;

   bus_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .i_clr     (w_tmo_clr),
      .i_en      (w_access),
      .o_expired (w_expired)
   );

   // IDLE grant; only meaningful when at least one master requests.
   always_comb begin
      w_grant = OWN_M0;
`ifdef BUS_ARB_ROUND_ROBIN_EN
      if (bus.i_m0_req && bus.i_m1_req)
         w_grant = (r_last == OWN_M0) ? OWN_M1 : OWN_M0;
      else if (bus.i_m1_req)
         w_grant = OWN_M1;
`else
      if (!bus.i_m0_req && bus.i_m1_req)
         w_grant = OWN_M1;
`endif
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state <= ST_IDLE;
         r_owner <= OWN_M0;
         r_hold  <= '0;
         r_err   <= 1'b0;
`ifdef BUS_ARB_ROUND_ROBIN_EN
         r_last  <= OWN_M1;
`endif
      end else begin
         r_state <= w_state_nxt;
         r_owner <= w_owner_nxt;
         r_hold  <= w_hold_nxt;
         r_err   <= w_timeout;
`ifdef BUS_ARB_ROUND_ROBIN_EN
         r_last  <= w_last_nxt;
`endif
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_owner_nxt = r_owner;
      w_hold_nxt  = r_hold;
`ifdef BUS_ARB_ROUND_ROBIN_EN
      w_last_nxt  = r_last;
`endif
      case (r_state)
         ST_IDLE: begin
            if (bus.i_m0_req || bus.i_m1_req) begin
               w_state_nxt = ST_ACCESS;
               w_owner_nxt = w_grant;
               w_hold_nxt  = '0;
            end
         end
         ST_ACCESS: begin
            if (w_abandon) begin
               // Owner's request is gone, so only the other master can win.
               w_hold_nxt = '0;
               if (w_oth_req) w_owner_nxt = w_other;
               else           w_state_nxt = ST_IDLE;
            end else if (w_complete) begin
`ifdef BUS_ARB_ROUND_ROBIN_EN
               w_last_nxt = r_owner;
`endif
               if (w_oth_req && (!w_own_req || r_hold == HOLD_MAX)) begin
                  w_owner_nxt = w_other;
                  w_hold_nxt  = '0;
               end else if (w_own_req) begin
                  if (r_hold != HOLD_MAX) w_hold_nxt = r_hold + HOLD_W'(1);
               end else if (w_oth_req) begin
                  w_owner_nxt = w_other;
                  w_hold_nxt  = '0;
               end else begin
                  w_state_nxt = ST_IDLE;
               end
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      bus.o_s_cs      = 1'b0;
      bus.o_s_we      = 1'b0;
      bus.o_s_addr    = '0;
      bus.o_s_dat     = '0;
      bus.o_m0_active = 1'b0;
      bus.o_m1_active = 1'b0;
      bus.o_m0_ack    = 1'b0;
      bus.o_m1_ack    = 1'b0;
      if (w_access) begin
         bus.o_s_cs = 1'b1;
         if (r_owner == OWN_M1) begin
            bus.o_s_addr    = bus.i_m1_addr;
            bus.o_s_dat     = bus.i_m1_dat;
            bus.o_s_we      = bus.i_m1_we;
            bus.o_m1_active = 1'b1;
            bus.o_m1_ack    = w_complete;
         end else begin
            bus.o_s_addr    = bus.i_m0_addr;
            bus.o_s_dat     = bus.i_m0_dat;
            bus.o_s_we      = bus.i_m0_we;
            bus.o_m0_active = 1'b1;
            bus.o_m0_ack    = w_complete;
         end
      end
   end

   assign bus.o_m_dat = bus.i_s_dat;
   assign bus.o_err   = r_err;

endmodule

// File: tb/tb_bus_arbiter.sv
module tb_bus_arbiter;
   import bus_pkg::*;

   localparam int MAX_HOLD = 4;
   localparam int TIMEOUT  = 15;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   bus_arbiter_if bif();

   bus_arbiter #(.MAX_HOLD(MAX_HOLD), .TIMEOUT(TIMEOUT)) dut (
      .i_clk     (clk),
      .i_reset_n (rst_n),
      .bus       (bif)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        act0, act1, ack0, ack1, cs, we, err;
      logic [15:0] addr;
      logic [7:0]  sdat, mdat;
   } obs_t;

   obs_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   bit busy;
   int who, streak, waited, prev;
   bit err_pend;

   function automatic void model_reset();
      busy = 0; who = 0; streak = 0; waited = 0; prev = 1; err_pend = 0;
   endfunction

   function automatic bit req_of(int m);
      return (m == 1) ? bif.i_m1_req : bif.i_m0_req;
   endfunction

   function automatic bit finishing();
      return busy && req_of(who) && (bif.i_s_ack || waited == TIMEOUT - 1);
   endfunction

   function automatic int pick();
`ifdef BUS_ARB_ROUND_ROBIN_EN
      if (bif.i_m0_req && bif.i_m1_req) return 1 - prev;
      return bif.i_m1_req ? 1 : 0;
`else
      return bif.i_m0_req ? 0 : 1;
`endif
   endfunction

   function automatic void push_expected();
      obs_t e;
      if (!rst_n) model_reset();
      e      = '0;
      e.mdat = bif.i_s_dat;
      e.err  = err_pend;
      if (busy) begin
         e.cs   = 1'b1;
         e.addr = (who == 1) ? bif.i_m1_addr : bif.i_m0_addr;
         e.sdat = (who == 1) ? bif.i_m1_dat  : bif.i_m0_dat;
         e.we   = (who == 1) ? bif.i_m1_we   : bif.i_m0_we;
         if (who == 1) begin e.act1 = 1'b1; e.ack1 = finishing(); end
         else          begin e.act0 = 1'b1; e.ack0 = finishing(); end
      end
      exp_q.push_back(e);
   endfunction

   function automatic void model_edge();
      bit d;
      int other;
      if (!rst_n) begin model_reset(); return; end
      d        = finishing();
      other    = 1 - who;
      err_pend = d && !bif.i_s_ack;
      if (!busy) begin
         if (bif.i_m0_req || bif.i_m1_req) begin
            who = pick(); busy = 1; streak = 0; waited = 0;
         end
      end else if (!req_of(who)) begin
         streak = 0; waited = 0;
         if (req_of(other)) who = other;
         else               busy = 0;
      end else if (d) begin
         prev = who; waited = 0;
         if (req_of(other) && streak == MAX_HOLD - 1) begin
            who = other; streak = 0;
         end else if (streak < MAX_HOLD - 1) begin
            streak++;
         end
      end else begin
         waited++;
      end
   endfunction

   always @(negedge clk) begin : monitor
      obs_t e, g;
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         g.act0 = bif.o_m0_active; g.act1 = bif.o_m1_active;
         g.ack0 = bif.o_m0_ack;    g.ack1 = bif.o_m1_ack;
         g.cs   = bif.o_s_cs;      g.we   = bif.o_s_we;
         g.err  = bif.o_err;       g.addr = bif.o_s_addr;
         g.sdat = bif.o_s_dat;     g.mdat = bif.o_m_dat;
         checks++;
         if (g !== e) begin
            errors++;
            $display("FAIL outputs @%0t got act=%b%b ack=%b%b cs=%b we=%b err=%b addr=%h sdat=%h mdat=%h want act=%b%b ack=%b%b cs=%b we=%b err=%b addr=%h sdat=%h mdat=%h",
               $time, g.act0, g.act1, g.ack0, g.ack1, g.cs, g.we, g.err, g.addr, g.sdat, g.mdat,
               e.act0, e.act1, e.ack0, e.ack1, e.cs, e.we, e.err, e.addr, e.sdat, e.mdat);
         end
      end
   end

   task automatic chk(input bit ok, input string what);
      checks++;
      if (ok !== 1'b1) begin
         errors++;
         $display("FAIL %s @%0t", what, $time);
      end
   endtask

   task automatic cyc();
      #2 push_expected();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic rnd_data();
      bif.i_m0_addr = 16'($urandom);
      bif.i_m1_addr = 16'($urandom);
      bif.i_m0_dat  = 8'($urandom);
      bif.i_m1_dat  = 8'($urandom);
      bif.i_m0_we   = 1'($urandom_range(0, 1));
      bif.i_m1_we   = 1'($urandom_range(0, 1));
      bif.i_s_dat   = 8'($urandom);
   endtask

   task automatic set_req(input bit r0, input bit r1, input bit ack);
      bif.i_m0_req = r0;
      bif.i_m1_req = r1;
      bif.i_s_ack  = ack;
   endtask

   initial begin
      int ack_div;
      model_reset();
      set_req(0, 0, 0);
      rnd_data();
      @(posedge clk); #1;

      repeat (3) begin
         rnd_data();
         set_req(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         cyc();
         chk(!bif.o_s_cs && !bif.o_s_we && bif.o_s_addr == 16'h0 && bif.o_s_dat == 8'h0 &&
             !bif.o_m0_active && !bif.o_m1_active && !bif.o_m0_ack && !bif.o_m1_ack &&
             !bif.o_err, "reset state");
      end
      rst_n = 1'b1;
      set_req(0, 0, 0);
      cyc(); cyc();

      bif.i_m0_addr = 16'h1234; bif.i_m0_we = 1'b0;
      set_req(1, 0, 0);
      cyc(); cyc();
      bif.i_s_dat = 8'hA5; bif.i_s_ack = 1'b1;
      cyc();
      set_req(0, 0, 0);
      cyc(); cyc();

      set_req(1, 1, 1);
      repeat (14) begin rnd_data(); cyc(); end
      set_req(0, 0, 0);
      cyc(); cyc();

      bif.i_m1_addr = 16'h8000; bif.i_m1_dat = 8'h55; bif.i_m1_we = 1'b1;
      set_req(0, 1, 0);
      repeat (15) cyc();
      chk(bif.o_m1_ack && !bif.o_m0_ack && bif.o_s_cs && bif.o_s_we &&
          bif.o_s_addr == 16'h8000 && bif.o_s_dat == 8'h55 && !bif.o_err, "expired-wait ack");
      cyc();
      chk(bif.o_err && !bif.o_m1_ack, "expired-wait err pulse");
      set_req(0, 0, 0);
      cyc(); cyc(); cyc();

      repeat (2) begin
         set_req(1, 1, 1);
         rnd_data(); cyc(); cyc();
         set_req(0, 0, 0);
         cyc(); cyc();
      end

      set_req(1, 0, 0);
      rnd_data(); cyc(); cyc();
      rst_n = 1'b0; cyc();
      rst_n = 1'b1; cyc(); cyc();
      bif.i_s_ack = 1'b1; cyc();
      set_req(0, 0, 0); cyc(); cyc();

      set_req(1, 1, 0);
      rnd_data(); cyc(); cyc();
      bif.i_m0_req = 1'b0; cyc();
      bif.i_s_ack = 1'b1; cyc();
      set_req(0, 0, 0); cyc(); cyc();

      ack_div = 2;
      for (int i = 0; i < 3000; i++) begin
         if (i % 64 == 0) ack_div = (($urandom_range(0, 2)) == 0) ? 40 : $urandom_range(1, 4);
         rnd_data();
         if ($urandom_range(0, 7) == 0) bif.i_m0_req = ~bif.i_m0_req;
         if ($urandom_range(0, 7) == 0) bif.i_m1_req = ~bif.i_m1_req;
         bif.i_s_ack = ($urandom_range(0, ack_div - 1) == 0);
         rst_n = ($urandom_range(0, 299) != 0);
         cyc();
      end

      rst_n = 1'b1;
      set_req(0, 0, 0);
      cyc(); cyc();
      @(negedge clk); #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter MAX_HOLD, default 4: maximum consecutive accesses one master may complete while the other master is requesting.
REQ-002 Parameter TIMEOUT, default 15: cycles in ACCESS without i_s_ack before the access is force-completed.
REQ-003 Ports, one per line: name, direction, width, meaning.
- i_clk  in  1  single clock, all state on rising edge.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_m0_req, i_m1_req  in  1  master 0 (CPU) / master 1 (DMA) access request.
- i_m0_addr, i_m1_addr  in  16  master address.
- i_m0_dat, i_m1_dat  in  8  master write data.
- i_m0_we, i_m1_we  in  1  master write enable.
- o_m0_active, o_m1_active  out  1  master owns the bus this cycle.
- o_m0_ack, o_m1_ack  out  1  access completes this cycle.
- o_m_dat  out  8  read data, shared by both masters.
- o_s_addr  out  16  slave address.
- o_s_dat  out  8  slave write data.
- o_s_we  out  1  slave write enable.
- o_s_cs  out  1  slave select.
- i_s_dat  in  8  slave read data.
- i_s_ack  in  1  slave completion.
- o_err  out  1  one-cycle pulse after a timeout.

Function
REQ-004 FSM states: IDLE, ACCESS; registers: owner (0/1), hold count, timeout count, last-owner.
REQ-005 IDLE: no request -> stay IDLE; one request -> ACCESS with that owner on the next edge; both -> winner per REQ-013.
REQ-006 ACCESS: o_s_cs=1; o_s_addr/o_s_dat/o_s_we are combinational muxes of the owner's inputs; o_mX_active=1 for the owner only.
REQ-007 IDLE: o_s_cs, o_s_we, o_s_addr, o_s_dat, o_m0_active, o_m1_active are all 0.
REQ-008 Completion = ACCESS and (i_s_ack or timeout count == TIMEOUT-1); owner's o_mX_ack = completion, combinational, same cycle; o_m_dat = i_s_dat passthrough at all times.
REQ-009 Completion without i_s_ack is a timeout; o_err=1 for exactly the following cycle; a forced write or read is still acked.
REQ-010 On completion, next state: other master requesting and (owner not requesting or hold count == MAX_HOLD-1) -> ACCESS, owner switched, hold count 0; else owner still requesting -> stay ACCESS, hold count+1 (saturating at MAX_HOLD-1); else other requesting -> switch owner; else IDLE.
REQ-011 Owner drops its request in ACCESS before completion: access abandoned, no ack, next state per REQ-005 evaluated on that edge.
REQ-012 Timeout count clears on entry to ACCESS and after every completion; increments each non-completing ACCESS cycle.
REQ-013 Simultaneous requests in IDLE: master 0 wins (fixed priority) unless REQ-018 applies.
REQ-014 Access latency: request sampled in IDLE at edge N -> o_s_cs high from edge N to first completion; back-to-back accesses by the same owner have zero idle cycles.

Reset
REQ-015 i_reset_n low: state IDLE, owner 0, last-owner 1, counters 0, o_err 0, asynchronously, regardless of the access in progress; no ack is issued for an interrupted access.
REQ-016 All outputs take their IDLE values (REQ-007) while reset is asserted.

Configuration
REQ-017 Macro BUS_ARB_ROUND_ROBIN_EN selects the tie-break policy.
REQ-018 With BUS_ARB_ROUND_ROBIN_EN defined: simultaneous requests in IDLE grant the master that is not last-owner; last-owner updates on every completion. Without the macro: fixed priority per REQ-013 and the last-owner register is absent.

Structure
REQ-019 Package bus_pkg holds the FSM state enum, the owner encoding, and the 16-bit address / 8-bit data width constants.
REQ-020 Sub-module bus_timeout holds the timeout counter; it takes clear/enable inputs and outputs an expiry flag. FSM, hold count and muxing stay in bus_arbiter.

Verification
REQ-021 Only m0 requests a read of 0x1234, slave acks on 2nd ACCESS cycle with 0xA5 -> o_s_addr=0x1234, o_m0_ack high that cycle, o_m_dat=0xA5, o_m1_active=0 throughout.
REQ-022 Both request continuously, slave acks every cycle, MAX_HOLD=4 -> ownership pattern m0 x4, m1 x4, m0 x4; no IDLE cycles.
REQ-023 m1 writes 0x55 to 0x8000, slave never acks, TIMEOUT=15 -> o_m1_ack on 15th ACCESS cycle, o_err high the next cycle, then IDLE.
REQ-024 Both request simultaneously from IDLE twice, separated by IDLE -> m0 wins both times without the macro; m0 then m1 with BUS_ARB_ROUND_ROBIN_EN.
REQ-025 i_reset_n pulled low mid-access -> outputs go to IDLE values immediately, no ack; after release, m0's pending request is granted on the next edge.
REQ-026 m0 drops its request before the ack while m1 is requesting -> no o_m0_ack; m1 owns the bus from the next cycle.
